// File: rtl/serial_add_seq.sv
// serial_add_seq
//   Bit-serial adder sequencer. Adds two WIDTH-bit operands plus a carry-in
//   with one shared single-bit full adder, one bit per clock, LSB first.
//   A start/busy/done handshake sequences each operation.
//
// Parameters
//   WIDTH  operand/sum width in bits (1..32)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only while idle
//   a, b   in   WIDTH  operands, captured when start is accepted
//   cin    in   1      carry-in, captured when start is accepted
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse when sum/cout have just been updated
//   sum    out  WIDTH  last completed sum (held between operations)
//   cout   out  1      last completed carry-out (held between operations)

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [1:0]       w_fa;
  logic [WIDTH:0]   w_psum_ext;
  logic [WIDTH-1:0] w_psum_nxt;
  logic             w_last;

  // Single-bit full adder cell: returns {carry_out, sum_bit}.
  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    fa = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  assign w_fa       = fa(r_a_sh[0], r_b_sh[0], r_carry);
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  // Building it through a WIDTH+1 vector keeps the slice legal for WIDTH=1.
  assign w_psum_ext = {w_fa[0], r_psum};
  assign w_psum_nxt = w_psum_ext[WIDTH:1];
  assign w_last     = (r_cnt == LAST_BIT);

  always_comb begin
    w_state_nxt = IDLE;
    unique case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand shifters, carry, bit counter and result registers. The result
  // registers only move on the final bit edge, so they hold across later ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_psum  <= '0;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_psum  <= w_psum_nxt;
          r_carry <= w_fa[1];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_sum  <= w_psum_nxt;
            r_cout <= w_fa[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  // WIDTH=3 instance
  logic       start3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, cout3;
  logic [2:0] sum3;
  // WIDTH=1 instance
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_seq #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3));
  serial_add_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Selected-instance view used by the generic operation task.
  int         sel = 0;
  logic       o_busy, o_done, o_cout;
  logic [7:0] o_sum;
  always_comb begin
    o_busy = busy8; o_done = done8; o_cout = cout8; o_sum = sum8;
    if (sel == 1) begin
      o_busy = busy3; o_done = done3; o_cout = cout3; o_sum = {5'd0, sum3};
    end else if (sel == 2) begin
      o_busy = busy1; o_done = done1; o_cout = cout1; o_sum = {7'd0, sum1};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input int s, input logic st, input logic [7:0] av,
                       input logic [7:0] bv, input logic cv);
    if (s == 0) begin start8 = st; a8 = av; b8 = bv; cin8 = cv; end
    else if (s == 1) begin start3 = st; a3 = av[2:0]; b3 = bv[2:0]; cin3 = cv; end
    else begin start1 = st; a1 = av[0:0]; b1 = bv[0:0]; cin1 = cv; end
  endtask

  // One complete operation with a start pulse; operands are scrambled right
  // after acceptance. exp = {cout, sum} computed by the caller.
  task automatic do_op(input int s, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic [8:0] exp, input string tag);
    int         w, k;
    bit         busy_ok, hold_ok;
    logic [7:0] prev_sum;
    logic       prev_cout;
    w = (s == 0) ? 8 : (s == 1) ? 3 : 1;
    sel = s;
    @(negedge clk);
    drive(s, 1'b1, av, bv, cv);
    #1;
    prev_sum  = o_sum;
    prev_cout = o_cout;
    @(posedge clk); #1;
    @(negedge clk);
    drive(s, 1'b0, ~av, ~bv, ~cv);
    k = 0; busy_ok = 1; hold_ok = 1;
    while (!o_done && k < 40) begin
      if (o_busy !== 1'b1) busy_ok = 0;
      if (o_sum !== prev_sum || o_cout !== prev_cout) hold_ok = 0;
      @(posedge clk); #1;
      k++;
    end
    check({tag, " latency"}, k, w);
    check({tag, " busy_in_run"}, busy_ok, 1);
    check({tag, " result_hold"}, hold_ok, 1);
    check({tag, " busy_in_done"}, o_busy, 0);
    check({tag, " result"}, {o_cout, o_sum}, exp);
    @(posedge clk); #1;
    check({tag, " done_pulse_1cyc"}, o_done, 0);
  endtask

  initial begin
    int t1, t2, nd;
    logic [8:0] e;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy8, 0);
    check("rst done", done8, 0);
    check("rst sum", sum8, 8'h00);
    check("rst cout", cout8, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle no start busy", busy8, 0);

    // Directed WIDTH=8 vectors
    do_op(0, 8'h5A, 8'h3C, 1'b0, 9'h096, "t1 5A+3C");
    do_op(0, 8'hFF, 8'h01, 1'b0, 9'h100, "t2 FF+01");
    do_op(0, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "t2 FF+FF+1");

    // Start held high: back-to-back ops every WIDTH+2 cycles
    sel = 0;
    @(negedge clk); drive(0, 1'b1, 8'h10, 8'h20, 1'b0);
    t1 = -1; t2 = -1;
    for (int i = 0; i < 40 && t2 < 0; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        if (t1 < 0) t1 = cyc; else t2 = cyc;
      end
    end
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("t3 done spacing", t2 - t1, 10);
    check("t3 held result", {cout8, sum8}, 9'h030);
    repeat (2) @(posedge clk);
    #1;
    check("t3 idle after drop", busy8, 0);

    // Start re-asserted and operands changed mid-RUN
    @(negedge clk); drive(0, 1'b1, 8'h12, 8'h34, 1'b1);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 8'h12, 8'h34, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); drive(0, 1'b1, 8'hFF, 8'hFF, 1'b1);
    nd = 0;
    for (int i = 0; i < 20 && nd == 0; i++) begin
      @(posedge clk); #1;
      if (done8) nd = 1;
    end
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    check("t4 done seen", nd, 1);
    check("t4 original result", {cout8, sum8}, 9'h047);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("t4 no extra done", nd, 0);

    // Reset in the 4th RUN cycle
    @(negedge clk); drive(0, 1'b1, 8'hAA, 8'h55, 1'b0);
    @(posedge clk);
    @(negedge clk); drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5 busy before rst", busy8, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("t5 rst busy", busy8, 0);
    check("t5 rst done", done8, 0);
    check("t5 rst result", {cout8, sum8}, 9'h000);
    @(negedge clk); rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) nd++;
    end
    check("t5 no done after abort", nd, 0);
    do_op(0, 8'h80, 8'h80, 1'b0, 9'h100, "t5 80+80");

    // WIDTH=3 exhaustive
    for (int v = 0; v < 128; v++) begin
      logic [2:0] av, bv;
      logic       cv;
      av = v[2:0]; bv = v[5:3]; cv = v[6];
      e = 9'(av) + 9'(bv) + 9'(cv);
      // 3-bit result: cout is bit 3 of the true sum
      do_op(1, {5'd0, av}, {5'd0, bv}, cv, {e[3], 5'd0, e[2:0]}, $sformatf("w3 v%0d", v));
    end

    // WIDTH=1 against the full-adder truth table
    for (int v = 0; v < 8; v++) begin
      logic x, y, c, s_t, c_t;
      x = v[0]; y = v[1]; c = v[2];
      case ({x, y, c})
        3'b000: {c_t, s_t} = 2'b00;
        3'b001, 3'b010, 3'b100: {c_t, s_t} = 2'b01;
        3'b011, 3'b101, 3'b110: {c_t, s_t} = 2'b10;
        default: {c_t, s_t} = 2'b11;
      endcase
      do_op(2, {7'd0, x}, {7'd0, y}, c, {c_t, 7'd0, s_t}, $sformatf("w1 v%0d", v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
